// File: rtl/ecap5_dproc_pkg.sv
// Shared types and constants for the Wishbone memory slave.
package ecap5_dproc_pkg;

  localparam int unsigned WB_ADR_W = 32;
  localparam int unsigned WB_DAT_W = 32;
  localparam int unsigned WB_SEL_W = 4;

  localparam logic [15:0] WB_MEM_LFSR_SEED = 16'hACE1;

  // One accepted Wishbone request as it travels down the delay line.
  typedef struct packed {
    logic [WB_ADR_W-1:0] adr;
    logic [WB_DAT_W-1:0] dat;
    logic                we;
    logic [WB_SEL_W-1:0] sel;
  } wb_req_t;

endpackage

// File: rtl/wb_req_delay.sv
// Fixed-depth shift line of {valid, wb_req_t} with synchronous flush.
// STAGES=0 degenerates to a pass-through (request retires on its accept edge).
module wb_req_delay
  import ecap5_dproc_pkg::*;
#(
  parameter int unsigned STAGES = 1
) (
  input  logic    clk,
  input  logic    flush,
  input  logic    in_valid,
  input  wb_req_t in_req,
  output logic    out_valid,
  output wb_req_t out_req
);

  if (STAGES == 0) begin : g_pass
    logic unused_clk_c;
    assign unused_clk_c = clk;
    assign out_valid    = in_valid & ~flush;
    assign out_req      = in_req;
  end else begin : g_shift
    logic [STAGES-1:0] vld_q;
    wb_req_t           req_q [STAGES];

    // Valid bits shift every cycle; flush empties the line.
    always_ff @(posedge clk) begin
      if (flush) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= in_valid;
        for (int i = 1; i < int'(STAGES); i++) begin
          vld_q[i] <= vld_q[i-1];
        end
      end
    end

    // Payload shifts unconditionally; only the valid bits carry meaning.
    always_ff @(posedge clk) begin
      req_q[0] <= in_req;
      for (int i = 1; i < int'(STAGES); i++) begin
        req_q[i] <= req_q[i-1];
      end
    end

    assign out_valid = vld_q[STAGES-1];
    assign out_req   = req_q[STAGES-1];
  end

endmodule

// File: rtl/wb_mem_slave.sv
// Pipelined Wishbone B4 word-memory slave with fixed ACK latency and an
// outstanding-request limit. Optional random stall injection is enabled
// by defining WB_MEM_STALL_INJECT_EN.
module wb_mem_slave
  import ecap5_dproc_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = 10,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned MAX_PENDING = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [WB_ADR_W-1:0] wb_adr_i,
  input  logic [WB_DAT_W-1:0] wb_dat_i,
  output logic [WB_DAT_W-1:0] wb_dat_o,
  input  logic                wb_we_i,
  input  logic [WB_SEL_W-1:0] wb_sel_i,
  input  logic                wb_stb_i,
  output logic                wb_ack_o,
  input  logic                wb_cyc_i,
  output logic                wb_stall_o
);

  localparam int unsigned CNT_W = $clog2(MAX_PENDING + 1);
  localparam int unsigned WORDS = 2 ** ADDR_BITS;

  logic [WB_DAT_W-1:0] mem [WORDS];
  logic [CNT_W-1:0]    pend_q;
  logic                inj_stall_c;
  logic                accept_c;
  logic                flush_c;
  wb_req_t             acc_req_c;
  logic                ret_valid_c;
  wb_req_t             ret_req_c;
  logic [ADDR_BITS-1:0] ret_idx_c;
  logic                unused_adr_c;

  assign accept_c   = wb_cyc_i & wb_stb_i & ~wb_stall_o;
  assign flush_c    = ~rst_i | ~wb_cyc_i;
  assign acc_req_c  = '{adr: wb_adr_i, dat: wb_dat_i, we: wb_we_i, sel: wb_sel_i};
  assign ret_idx_c  = ret_req_c.adr[ADDR_BITS+1:2];
  assign unused_adr_c = ^{ret_req_c.adr[WB_ADR_W-1:ADDR_BITS+2], ret_req_c.adr[1:0]};

  // Stall on full pending count (registered, so a same-cycle retire does not release it).
  assign wb_stall_o = (pend_q == CNT_W'(MAX_PENDING)) | inj_stall_c | ~rst_i;

`ifdef WB_MEM_STALL_INJECT_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1; bit0 injects a stall.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      lfsr_q <= WB_MEM_LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign inj_stall_c = lfsr_q[0];
`else
  assign inj_stall_c = 1'b0;
`endif

  wb_req_delay #(
    .STAGES (LATENCY - 1)
  ) u_delay (
    .clk       (clk_i),
    .flush     (flush_c),
    .in_valid  (accept_c),
    .in_req    (acc_req_c),
    .out_valid (ret_valid_c),
    .out_req   (ret_req_c)
  );

  // Retire: ACK register, read data and pending count; cyc drop acts like reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i || !wb_cyc_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      pend_q   <= '0;
    end else begin
      wb_ack_o <= ret_valid_c;
      wb_dat_o <= (ret_valid_c && !ret_req_c.we) ? mem[ret_idx_c] : '0;
      case ({accept_c, ret_valid_c})
        2'b10:   pend_q <= pend_q + CNT_W'(1);
        2'b01:   pend_q <= pend_q - CNT_W'(1);
        default: pend_q <= pend_q;
      endcase
    end
  end

  // Byte-masked write on retire; array is never reset.
  always_ff @(posedge clk_i) begin
    if (rst_i && wb_cyc_i && ret_valid_c && ret_req_c.we) begin
      for (int b = 0; b < int'(WB_SEL_W); b++) begin
        if (ret_req_c.sel[b]) begin
          mem[ret_idx_c][8*b +: 8] <= ret_req_c.dat[8*b +: 8];
        end
      end
    end
  end

endmodule
